// File: rtl/text_char_renderer_pkg.sv
// Shared constants, attribute layout and address helpers for the 100x60 text-mode renderer.
package text_char_renderer_pkg;

    localparam int TEXT_COLS       = 100;
    localparam int TEXT_ADDR_WIDTH = 13;
    localparam int FONT_ADDR_WIDTH = 12;
    localparam int COLOUR_WIDTH    = 4;
    localparam int BLINK_BIT       = 5;
    localparam int FRAME_CNT_WIDTH = 6;

    // Text RAM word: background in the top nibble, foreground next, code in the low byte.
    typedef struct packed {
        logic [COLOUR_WIDTH-1:0] bg;
        logic [COLOUR_WIDTH-1:0] fg;
        logic [7:0]              code;
    } attr_t;

    // Row-major cell address; the largest value (5999) fits in 13 bits.
    function automatic logic [TEXT_ADDR_WIDTH-1:0] cell_addr(input logic [6:0] x,
                                                             input logic [5:0] y);
        return TEXT_ADDR_WIDTH'(y) * TEXT_ADDR_WIDTH'(TEXT_COLS) + TEXT_ADDR_WIDTH'(x);
    endfunction

    // The cursor underline occupies the two bottom glyph rows.
    function automatic logic cursor_band(input logic [3:0] ychar);
        return (ychar == 4'd8) || (ychar == 4'd9);
    endfunction

endpackage

// File: rtl/text_char_renderer_char_shifter.sv
// Glyph design register, 8-bit pixel shifter and fg/bg selection driving the registered colour/blank.
module char_shifter
    import text_char_renderer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    font_latch_i,
    input  logic                    invert_i,
    input  logic [7:0]              font_data_i,
    input  logic                    draw_i,
    input  logic                    drawing_i,
    input  logic [COLOUR_WIDTH-1:0] fg_i,
    input  logic [COLOUR_WIDTH-1:0] bg_i,
    output logic [COLOUR_WIDTH-1:0] colour_o,
    output logic                    blank_o
);

    logic [7:0]              design_q, design_d;
    logic [7:0]              shift_q, shift_d;
    logic [COLOUR_WIDTH-1:0] fg_q, fg_d, bg_q, bg_d;
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
    logic                    blank_q, blank_d;

    always_comb begin
        design_d = design_q;
        shift_d  = shift_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        colour_d = '0;
        blank_d  = 1'b1;
        if (font_latch_i) begin
            design_d = font_data_i ^ {8{invert_i}};
        end
        // Private attribute copy so the next cell's prefetch cannot recolour this one.
        if (draw_i) begin
            fg_d = fg_i;
            bg_d = bg_i;
        end
        if (drawing_i) begin
            blank_d = 1'b0;
            if (draw_i) begin
                shift_d  = design_q << 1;
                colour_d = design_q[7] ? fg_i : bg_i;
            end else begin
                shift_d  = shift_q << 1;
                colour_d = shift_q[7] ? fg_q : bg_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            design_q <= '0;
            shift_q  <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            colour_q <= '0;
            blank_q  <= 1'b1;
        end else begin
            design_q <= design_d;
            shift_q  <= shift_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            colour_q <= colour_d;
            blank_q  <= blank_d;
        end
    end

    assign colour_o = colour_q;
    assign blank_o  = blank_q;

endmodule

// File: rtl/text_char_renderer.sv
// Character-cell renderer: text RAM fetch, font ROM fetch, pixel serialisation.
// Optional blinking cursor is built when the CURSOR_EN macro is defined.
module text_char_renderer
    import text_char_renderer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clk_load_char,
    input  logic                       clk_load_design,
    input  logic                       clk_draw_char,
    input  logic                       drawing,
    input  logic                       vsync,
    input  logic [6:0]                 xtext,
    input  logic [5:0]                 ytext,
    input  logic [3:0]                 ychar,
    output logic [TEXT_ADDR_WIDTH-1:0] text_addr,
    input  logic [15:0]                text_data,
    output logic [FONT_ADDR_WIDTH-1:0] font_addr,
    input  logic [7:0]                 font_data,
    input  logic [6:0]                 cursor_col,
    input  logic [5:0]                 cursor_row,
    output logic [COLOUR_WIDTH-1:0]    colour,
    output logic                       blank
);

    attr_t                      word;
    logic [TEXT_ADDR_WIDTH-1:0] text_addr_q, text_addr_d;
    logic [FONT_ADDR_WIDTH-1:0] font_addr_q, font_addr_d;
    logic [3:0]                 ychar_q, ychar_d;
    logic [COLOUR_WIDTH-1:0]    fg_q, fg_d, bg_q, bg_d;
    logic [1:0]                 ld_dly_q;
    logic                       invert;

    assign word = attr_t'(text_data);

    always_comb begin
        text_addr_d = text_addr_q;
        ychar_d     = ychar_q;
        font_addr_d = font_addr_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        if (clk_load_char) begin
            text_addr_d = cell_addr(xtext, ytext);
            ychar_d     = ychar;
        end
        if (clk_load_design) begin
            font_addr_d = {word.code, ychar_q};
            fg_d        = word.fg;
            bg_d        = word.bg;
        end
    end

    // ld_dly_q[1] marks the cycle the font ROM output belongs to this cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            text_addr_q <= '0;
            font_addr_q <= '0;
            ychar_q     <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            ld_dly_q    <= '0;
        end else begin
            text_addr_q <= text_addr_d;
            font_addr_q <= font_addr_d;
            ychar_q     <= ychar_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            ld_dly_q    <= {ld_dly_q[0], clk_load_design};
        end
    end

`ifdef CURSOR_EN
    logic                       vsync_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_q, frame_d;
    logic                       hit_q, hit_d;

    always_comb begin
        frame_d = frame_q;
        hit_d   = hit_q;
        if (vsync_q && !vsync) begin
            frame_d = frame_q + 1'b1;
        end
        if (clk_load_char) begin
            hit_d = (xtext == cursor_col) && (ytext == cursor_row);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            frame_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            vsync_q <= vsync;
            frame_q <= frame_d;
            hit_q   <= hit_d;
        end
    end

    assign invert = hit_q && frame_q[BLINK_BIT] && cursor_band(ychar_q);
`else
    logic unused_cursor;
    assign unused_cursor = ^{vsync, cursor_col, cursor_row};
    assign invert        = 1'b0;
`endif

    char_shifter u_shifter (
        .clk          (clk),
        .rst_n        (reset_n),
        .font_latch_i (ld_dly_q[1]),
        .invert_i     (invert),
        .font_data_i  (font_data),
        .draw_i       (clk_draw_char),
        .drawing_i    (drawing),
        .fg_i         (fg_q),
        .bg_i         (bg_q),
        .colour_o     (colour),
        .blank_o      (blank)
    );

    assign text_addr = text_addr_q;
    assign font_addr = font_addr_q;

endmodule

// File: tb/tb_text_char_renderer.sv
// Self-checking bench for text_char_renderer: memory models, cell-level pixel model, directed cells.
module tb_text_char_renderer;

`ifdef CURSOR_EN
    localparam bit CUR_EN = 1'b1;
`else
    localparam bit CUR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_load_char = 1'b0, clk_load_design = 1'b0, clk_draw_char = 1'b0;
    logic        drawing = 1'b0, vsync = 1'b1;
    logic [6:0]  xtext = '0;
    logic [5:0]  ytext = '0;
    logic [3:0]  ychar = '0;
    logic [12:0] text_addr;
    logic [15:0] text_data = '0;
    logic [11:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [6:0]  cursor_col = '0;
    logic [5:0]  cursor_row = '0;
    logic [3:0]  colour;
    logic        blank;

    text_char_renderer dut (
        .clk(clk), .reset_n(reset_n),
        .clk_load_char(clk_load_char), .clk_load_design(clk_load_design),
        .clk_draw_char(clk_draw_char), .drawing(drawing), .vsync(vsync),
        .xtext(xtext), .ytext(ytext), .ychar(ychar),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row),
        .colour(colour), .blank(blank)
    );

    always #10 clk = ~clk;

    logic [15:0] tram [0:8191];
    logic [7:0]  from [0:4095];

    always @(posedge clk) begin
        text_data <= tram[text_addr];
        font_data <= from[font_addr];
    end

    int tests = 0, fails = 0;
    int falls = 0;
    logic d_lc = 0, d_ld = 0, d_dc = 0, d_dr = 0, d_vs = 1;
    int d_x = 0, d_y = 0, d_yc = 0;
    int pend_x = 0, pend_y = 0, pend_yc = 0;
    int pix_q[$];
    bit prev_vld = 0;
    int prev_c = 0, prev_b = 0;
    int cx [8], cy [8], cyc [8];
    logic [3:0] lit_seq [8] = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pixel colours a cell must produce, straight from the memory contents.
    task automatic push_cell(input int x, input int y, input int yc);
        logic [15:0] w;
        logic [7:0]  g;
        bit          inv;
        w   = tram[y * 100 + x];
        g   = from[int'(w[7:0]) * 16 + yc];
        inv = CUR_EN && (x == int'(cursor_col)) && (y == int'(cursor_row)) &&
              (yc == 8 || yc == 9) && ((falls % 64) >= 32);
        if (inv) g = ~g;
        pix_q.delete();
        for (int i = 7; i >= 0; i--) pix_q.push_back(g[i] ? int'(w[11:8]) : int'(w[15:12]));
    endtask

    task automatic tick();
        int exp_c, exp_b;
        @(posedge clk); #1;
        clk_load_char = d_lc; clk_load_design = d_ld; clk_draw_char = d_dc;
        drawing = d_dr; vsync = d_vs;
        xtext = 7'(d_x); ytext = 6'(d_y); ychar = 4'(d_yc);
        if (d_dr) begin
            if (d_dc) push_cell(pend_x, pend_y, pend_yc);
            exp_c = (pix_q.size() > 0) ? pix_q.pop_front() : -1;
            exp_b = 0;
        end else begin
            exp_c = 0;
            exp_b = 1;
        end
        if (d_lc) begin
            pend_x = d_x; pend_y = d_y; pend_yc = d_yc;
        end
        @(negedge clk);
        if (prev_vld) begin
            check("pixel_colour", int'(colour), prev_c);
            check("pixel_blank", int'(blank), prev_b);
        end
        prev_vld = (exp_c >= 0);
        prev_c   = exp_c;
        prev_b   = exp_b;
    endtask

    task automatic run_line(input int n, input int mode, input int lit_val, input int stop_at);
        int k, ph;
        for (int c = 0; c < 8 * n + 9; c++) begin
            k  = c / 8;
            ph = c % 8;
            d_lc = (ph == 0 && k < n);
            d_ld = (ph == 2 && k < n);
            d_dc = (ph == 7 && k < n);
            d_dr = (c >= 7 && c < 7 + 8 * n);
            if (k < n) begin
                d_x = cx[k]; d_y = cy[k]; d_yc = cyc[k];
            end
            tick();
            if (mode == 1) begin
                if (c == 1) check("text_addr_203", int'(text_addr), 203);
                if (c == 3) check("font_addr_415", int'(font_addr), 'h415);
                if (c >= 8 && c <= 15) check("lit_colour_a5", int'(colour), int'(lit_seq[c - 8]));
                if (c == 16) begin
                    check("drawing_off_colour", int'(colour), 0);
                    check("drawing_off_blank", int'(blank), 1);
                end
            end else if (mode == 2) begin
                if (c >= 8 && c <= 15) check("cursor_colour", int'(colour), lit_val);
            end
            if (c == stop_at) break;
        end
        d_lc = 0; d_ld = 0; d_dc = 0; d_dr = 0;
    endtask

    task automatic vsync_falls(input int n);
        for (int i = 0; i < n; i++) begin
            d_vs = 0; falls++;
            tick(); tick();
            d_vs = 1;
            tick(); tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) tram[i] = '0;
        for (int i = 0; i < 4096; i++) from[i] = '0;
        tram[203]  = 16'h1F41; from['h415] = 8'hA5; from['h419] = 8'h00;
        tram[10]   = 16'h2A41; from['h413] = 8'h3C;
        tram[11]   = 16'h5C42; from['h423] = 8'hF0;
        tram[12]   = 16'h0E43; from['h433] = 8'h81;
        tram[13]   = 16'h7344; from['h443] = 8'hFF;
        tram[5999] = 16'h9650; from['h507] = 8'h5A;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_text_addr", int'(text_addr), 0);
        check("reset_font_addr", int'(font_addr), 0);
        check("reset_colour", int'(colour), 0);
        check("reset_blank", int'(blank), 1);
        reset_n = 1'b1;

        cx[0] = 3; cy[0] = 2; cyc[0] = 5;
        run_line(1, 1, 0, -1);

        cx[0] = 10; cy[0] = 0;  cyc[0] = 3;
        cx[1] = 11; cy[1] = 0;  cyc[1] = 3;
        cx[2] = 12; cy[2] = 0;  cyc[2] = 3;
        cx[3] = 13; cy[3] = 0;  cyc[3] = 3;
        cx[4] = 99; cy[4] = 59; cyc[4] = 7;
        run_line(5, 0, 0, -1);

        cursor_col = 7'd3; cursor_row = 6'd2;
        vsync_falls(32);
        cx[0] = 3; cy[0] = 2; cyc[0] = 9;
        run_line(1, 2, CUR_EN ? 'hF : 'h1, -1);
        vsync_falls(32);
        run_line(1, 2, 'h1, -1);

        cx[0] = 10; cy[0] = 0; cyc[0] = 3;
        cx[1] = 11; cy[1] = 0; cyc[1] = 3;
        run_line(2, 0, 0, 12);
        check("pre_reset_colour_nonzero", int'(colour != 4'd0), 1);
        reset_n = 1'b0;
        #1;
        check("midreset_colour", int'(colour), 0);
        check("midreset_blank", int'(blank), 1);
        check("midreset_text_addr", int'(text_addr), 0);
        pix_q.delete();
        prev_vld = 0;
        falls = 0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        cx[0] = 3; cy[0] = 2; cyc[0] = 5;
        run_line(1, 1, 0, -1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
